// File: rtl/mux_scan_ctrl.sv
// Scan controller for an external 8:1 mux: steps sel over enabled channels, samples y_in into a word.
// Optional registered even parity on data_out when SCAN_PARITY_EN is defined.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] mask,
  output logic [2:0] sel,
  input  logic       y_in,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       parity
);

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSel,
    StSample,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] data_q, data_d;
  logic [7:0] higher;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Enabled channels strictly above the current one; empty means the scan is complete.
  assign higher = mask_q & (8'hFE << sel_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mask_d = mask;
          data_d = '0;
          cnt_d  = '0;
          if (mask == 8'h00) begin
            state_d = StDone;
          end else begin
            sel_d   = lowest_set(mask);
            state_d = StSel;
          end
        end
      end
      StSel: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        data_d[sel_q] = y_in;
        if (|higher) begin
          sel_d   = lowest_set(higher);
          state_d = StSel;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

`ifdef SCAN_PARITY_EN
  logic parity_q;

  // Tracks data_d so parity and data_out always change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^data_d;
    end
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

  assign sel      = sel_q;
  assign data_out = data_q;
  assign valid    = (state_q == StDone);
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: random and directed scans against a word-level model.
module tb_mux_scan_ctrl;

  localparam int unsigned SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [2:0] sel;
  logic       y_in;
  logic [7:0] data_out;
  logic       valid;
  logic       ready = 1'b0;
  logic       busy;
  logic       parity;

  logic [7:0] mux_in = 8'b10101010;
  assign y_in = mux_in[sel];

  mux_scan_ctrl #(.SETTLE(SETTLE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mask    (mask),
    .sel     (sel),
    .y_in    (y_in),
    .data_out(data_out),
    .valid   (valid),
    .ready   (ready),
    .busy    (busy),
    .parity  (parity)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] data;
    logic       par;
    int         vcyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic [2:0] obs[$];
  logic vprev = 1'b0;
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_parity(input logic [7:0] d);
`ifdef SCAN_PARITY_EN
    return ^d;
`else
    return 1'b0 & d[0];
`endif
  endfunction

  // Monitor: record channel visits, compare each completed scan against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      vprev = 1'b0;
      obs.delete();
    end else begin
      if (busy && !valid && (obs.size() == 0 || obs[$] != sel)) obs.push_back(sel);
      if (valid && !vprev) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          logic [7:0] vis;
          logic       asc;
          cur = sb.pop_front();
          vis = 8'h00;
          asc = 1'b1;
          for (int i = 0; i < obs.size(); i++) begin
            if (i > 0 && obs[i] <= obs[i-1]) asc = 1'b0;
            vis[obs[i]] = 1'b1;
          end
          check("data_out", 32'(data_out), 32'(cur.data));
          check("parity", 32'(parity), 32'(cur.par));
          check("latency", 32'(cyc), 32'(cur.vcyc));
          check("sel_visits", 32'(vis), 32'(cur.mask));
          check("sel_ascending", 32'(asc), 32'd1);
        end
        obs.delete();
      end else if (valid) begin
        check("hold_data", 32'(data_out), 32'(cur.data));
        check("hold_parity", 32'(parity), 32'(cur.par));
      end
      vprev = valid;
    end
  end

  // Caller is positioned just after a negedge; start is sampled on the next posedge.
  task automatic do_scan(input logic [7:0] m, input int rd, input bit poke);
    exp_t e;
    int   t;
    int   hi;
    e.mask = m;
    e.data = mux_in & m;
    e.par  = exp_parity(mux_in & m);
    e.vcyc = cyc + 1 + $countones(m) * (SETTLE + 1);
    sb.push_back(e);
    ready = (rd == 0);
    mask  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mask  = 8'($urandom);
    t = 0;
    while (!valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!valid) begin
      check("valid_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < rd; i++) begin
      if (poke && i == 1) begin
        start = 1'b1;
        mask  = 8'h0F;
      end
      @(negedge clk);
      start = 1'b0;
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("idle_valid", 32'(valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_retain", 32'(data_out), 32'(e.data));
    if (m != 8'h00) begin
      hi = 0;
      for (int i = 0; i < 8; i++) if (m[i]) hi = i;
      check("sel_hold", 32'(sel), 32'(hi));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_parity", 32'(parity), 32'd0);
    rst_n = 1'b1;
    do_scan(8'hFF, 0, 1'b0);
    do_scan(8'h0F, 0, 1'b0);
    do_scan(8'h00, 0, 1'b0);
    do_scan(8'hFF, 5, 1'b1);

    // Reset mid-scan: partial result discarded, then first post-reset edge accepts start.
    mask  = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_sel", 32'(sel), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_parity", 32'(parity), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_scan(8'hF0, 0, 1'b0);

    do_scan(8'h01, 0, 1'b0);
    do_scan(8'h02, 0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      mux_in = 8'($urandom);
      do_scan(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, range 1-15: cycles sel is held before each sample.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset.
REQ-003 Port clk SHALL be an input, 1 bit: the sole clock; all state updates on the rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-005 Port start SHALL be an input, 1 bit: scan request, sampled only in IDLE.
REQ-006 Port mask SHALL be an input, 8 bits: channel enable, bit n enables channel n; latched on accepted start.
REQ-007 Port sel SHALL be an output, 3 bits: channel select driving the downstream 8:1 mux select input.
REQ-008 Port y_in SHALL be an input, 1 bit: the 8:1 mux output.
REQ-009 Port data_out SHALL be an output, 8 bits: captured word, bit n = sample of channel n.
REQ-010 Port valid SHALL be an output, 1 bit: data_out holds a completed scan.
REQ-011 Port ready SHALL be an input, 1 bit: consumer accepts data_out.
REQ-012 Port busy SHALL be an output, 1 bit: high in every state except IDLE.
REQ-013 Port parity SHALL be an output, 1 bit: even parity of data_out (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, SEL, SAMPLE and DONE.
REQ-015 IDLE with start=1: latch mask and clear the capture register; go to SEL on the lowest enabled channel, or to DONE if mask=0.
REQ-016 SEL: sel = current channel, held for exactly SETTLE cycles, then go to SAMPLE.
REQ-017 SAMPLE: sel held; capture y_in into bit[current channel] at the end of the cycle.
REQ-018 Next channel: the next higher enabled channel (priority search, 0 cycles; disabled channels skipped); go to DONE after the highest enabled channel.
REQ-019 Disabled channel bits SHALL read 0 in data_out.
REQ-020 Channels SHALL be scanned in ascending order only, with no wrap-around within a scan.
REQ-021 DONE: data_out stable, valid=1; on valid&&ready go to IDLE and deassert valid the next cycle.
REQ-022 valid SHALL stay high and data_out SHALL stay constant while ready=0, for an unlimited time.
REQ-023 Latency: with N enabled channels, valid SHALL rise N*(SETTLE+1) cycles after the edge that samples start; for N=0, valid SHALL rise on that edge.
REQ-024 start SHALL be ignored while busy=1; start high in the same cycle as valid&&ready is not accepted until IDLE.
REQ-025 data_out SHALL retain the last scan in IDLE until the next accepted start clears it.
REQ-026 A mask change after start SHALL have no effect on the current scan.
REQ-027 sel SHALL hold its last value in IDLE and DONE.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, sel=0, data_out=0, valid=0, busy=0 and parity=0, including mid-scan; the partial scan is discarded.
REQ-029 The first start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-030 With macro SCAN_PARITY_EN defined, parity SHALL be a registered ^data_out, updated together with data_out, so it is valid whenever valid=1.
REQ-031 Without SCAN_PARITY_EN, the parity port SHALL exist and be tied to 0, with no parity logic.

Verification (bench instantiates this block driving a behavioural 8:1 mux, I=8'b10101010, SETTLE=1)
REQ-032 mask=8'hFF, start pulse, ready=1: valid exactly 16 cycles after start; data_out=8'hAA; sel sequence 0..7.
REQ-033 mask=8'h0F: valid after 8 cycles; data_out=8'h0A; sel never exceeds 3.
REQ-034 mask=8'h00: valid on the start edge; data_out=8'h00; no SEL/SAMPLE states visited.
REQ-035 mask=8'hFF, ready=0 for 5 cycles after valid: valid and data_out=8'hAA held; a start pulse during this window is ignored; ready=1 returns the FSM to IDLE.
REQ-036 rst_n pulsed low at cycle 6 of a scan: outputs zero immediately; a fresh scan with mask=8'hF0 yields 8'hA0.
REQ-037 SCAN_PARITY_EN defined, mask=8'h01: data_out=8'h00, parity=0; mask=8'h02: data_out=8'h02, parity=1; macro undefined: parity=0 always.
